// File: rtl/pulse_period_capture.sv
// rtl/pulse_period_capture.sv - input-capture timer measuring cycles between rising edges
// Publishes each interval with a one-cycle strobe; flags intervals longer than 2^WIDTH-1.
module pulse_period_capture #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             clear_in,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period_o,
    output logic             valid_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARM     = 2'b01,
        S_MEASURE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pulse_d;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_overflow;

    logic             w_rise;
    logic             w_capture;
    logic             w_overflow;

    // The delayed copy runs in every state so enabling on a held-high level sees no edge.
    assign w_rise     = pulse_in & ~r_pulse_d;
    assign w_capture  = enable_in && (r_state == S_MEASURE) && w_rise;
    assign w_overflow = enable_in && (r_state == S_MEASURE) && !w_rise && (r_count == C_MAX);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_in) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (!enable_in) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!enable_in) begin
                    w_state_nxt = S_IDLE;
                end else if (w_overflow) begin
                    w_state_nxt = S_ARM;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        state_o = r_state;
        busy_o  = (r_state == S_MEASURE);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_pulse_d <= 1'b0;
        end else begin
            r_pulse_d <= pulse_in;
        end
    end

    // Counting only happens while the next state is MEASURE; every exit path zeroes it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_count <= '0;
        end else if (w_state_nxt != S_MEASURE) begin
            r_count <= '0;
        end else if (w_rise) begin
            r_count <= C_ONE;
        end else begin
            r_count <= r_count + C_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_period <= r_count;
            end else if (clear_in) begin
                r_period <= '0;
            end
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end else if (clear_in) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign period_o   = r_period;
    assign valid_o    = r_valid;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_pulse_period_capture.sv
// tb/tb_pulse_period_capture.sv - scoreboard bench for pulse_period_capture
// Two instances: WIDTH=16 for nominal/level/disable cases, WIDTH=4 for overflow cases.
module tb_pulse_period_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en16 = 1'b0, clr16 = 1'b0, pul16 = 1'b0;
    logic        en4 = 1'b0, clr4 = 1'b0, pul4 = 1'b0;
    logic [15:0] period16;
    logic [3:0]  period4;
    logic        valid16, ovf16, busy16, valid4, ovf4, busy4;
    logic [1:0]  state16, state4;

    int n_total = 0;
    int n_bad   = 0;
    int q16[$];
    int q4[$];

    always #20 clk = ~clk;

    pulse_period_capture #(.WIDTH(16)) u_dut16 (
        .clk_in(clk), .reset_in(rst), .enable_in(en16), .clear_in(clr16), .pulse_in(pul16),
        .period_o(period16), .valid_o(valid16), .overflow_o(ovf16), .busy_o(busy16), .state_o(state16)
    );

    pulse_period_capture #(.WIDTH(4)) u_dut4 (
        .clk_in(clk), .reset_in(rst), .enable_in(en4), .clear_in(clr4), .pulse_in(pul4),
        .period_o(period4), .valid_o(valid4), .overflow_o(ovf4), .busy_o(busy4), .state_o(state4)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (valid16) begin
            if (q16.size() == 0) begin
                chk("w16 unexpected strobe period", int'(period16), -1);
            end else begin
                chk("w16 strobe period", int'(period16), q16.pop_front());
            end
        end
        if (valid4) begin
            if (q4.size() == 0) begin
                chk("w4 unexpected strobe period", int'(period4), -1);
            end else begin
                chk("w4 strobe period", int'(period4), q4.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic set_pul(input int d, input logic v);
        if (d == 0) pul16 = v;
        else        pul4  = v;
    endtask

    // One-cycle pulse followed by low time, so the next rise lands n cycles later.
    task automatic pulse_gap(input int d, input int n, input int exp_p);
        set_pul(d, 1'b1);
        if (exp_p > 0) begin
            if (d == 0) q16.push_back(exp_p);
            else        q4.push_back(exp_p);
        end
        step();
        set_pul(d, 1'b0);
        cyc(n - 1);
    endtask

    initial begin
        // Reset with pulse toggling
        rst = 1'b1;
        pul16 = 1'b1; pul4 = 1'b1;
        step();
        pul16 = 1'b0; pul4 = 1'b0;
        step();
        chk("reset period16", int'(period16), 0);
        chk("reset valid16", int'(valid16), 0);
        chk("reset ovf16", int'(ovf16), 0);
        chk("reset busy16", int'(busy16), 0);
        chk("reset state16", int'(state16), 0);
        chk("reset state4", int'(state4), 0);
        rst = 1'b0; en16 = 1'b1; en4 = 1'b0;
        step();
        chk("post-reset state16 enabled", int'(state16), 1);
        chk("post-reset state4 disabled", int'(state4), 0);

        // Nominal 16-cycle period
        pul16 = 1'b1;
        step();
        chk("busy after first edge", int'(busy16), 1);
        pul16 = 1'b0;
        cyc(15);
        for (int i = 0; i < 3; i++) pulse_gap(0, 16, 16);

        // Held level: 5 high, 3 low
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("held armed state", int'(state16), 1);
        for (int i = 0; i < 4; i++) begin
            pul16 = 1'b1;
            if (i > 0) q16.push_back(8);
            step();
            cyc(4);
            pul16 = 1'b0;
            cyc(3);
        end
        chk("held period", int'(period16), 8);
        chk("held state measure", int'(state16), 2);

        // Disable in the same cycle as a rise
        pul16 = 1'b1; en16 = 1'b0;
        step();
        chk("disable state", int'(state16), 0);
        chk("disable period kept", int'(period16), 8);
        cyc(2);
        en16 = 1'b1;
        step();
        cyc(3);
        chk("reenable high no edge", int'(state16), 1);
        pul16 = 1'b0;
        step();
        pulse_gap(0, 5, 0);
        chk("genuine edge arms measure", int'(state16), 2);

        // Clear together with a capture
        pul16 = 1'b1; clr16 = 1'b1;
        q16.push_back(5);
        step();
        chk("clear+capture period", int'(period16), 5);
        chk("clear+capture valid", int'(valid16), 1);
        clr16 = 1'b0; pul16 = 1'b0;
        step();
        clr16 = 1'b1;
        step();
        clr16 = 1'b0;
        chk("clear alone period", int'(period16), 0);

        // WIDTH=4 overflow
        rst = 1'b1; step(); rst = 1'b0;
        en4 = 1'b1;
        step();
        chk("w4 armed", int'(state4), 1);
        pul4 = 1'b1;
        step();
        pul4 = 1'b0;
        cyc(14);
        chk("w4 no overflow yet", int'(ovf4), 0);
        chk("w4 still measuring", int'(state4), 2);
        step();
        chk("w4 overflow set", int'(ovf4), 1);
        chk("w4 overflow to arm", int'(state4), 1);
        cyc(5);
        pulse_gap(1, 6, 0);
        chk("w4 restart measuring", int'(state4), 2);
        pul4 = 1'b1;
        q4.push_back(6);
        step();
        chk("w4 period after overflow", int'(period4), 6);
        chk("w4 overflow sticky", int'(ovf4), 1);
        pul4 = 1'b0;
        step();
        clr4 = 1'b1;
        step();
        clr4 = 1'b0;
        chk("w4 clear overflow", int'(ovf4), 0);
        chk("w4 clear period", int'(period4), 0);

        // Boundary: edges exactly 15 apart
        rst = 1'b1; step(); rst = 1'b0; step();
        pulse_gap(1, 15, 0);
        pul4 = 1'b1;
        q4.push_back(15);
        step();
        chk("w4 boundary period", int'(period4), 15);
        chk("w4 boundary no overflow", int'(ovf4), 0);
        pul4 = 1'b0;
        cyc(3);
        cyc(11);
        clr4 = 1'b1;
        step();
        clr4 = 1'b0;
        chk("w4 overflow beats clear", int'(ovf4), 1);
        chk("w4 clear period on overflow", int'(period4), 0);

        cyc(2);
        chk("w16 pending strobes", q16.size(), 0);
        chk("w4 pending strobes", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_period_capture.md
Name: pulse_period_capture

Overview:
- Input-capture timer; the measuring end of the counter/comparator pulse generators in this design.
- Receives a single-clock-wide or level pulse train, for example a comparator EQ_posedge output.
- Measures the clock-cycle distance between successive rising edges and publishes each result with a one-cycle valid strobe.
- Flags intervals too long to represent. Used to check generator periods in hardware and as a reusable capture unit.

Parameters:
- WIDTH, 16, width of the internal cycle counter and of period_o.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- enable_in  input  1  1 = capture active; 0 = idle, measurement discarded.
- clear_in  input  1  synchronous clear of overflow_o and period_o.
- pulse_in  input  1  monitored signal, already synchronous to clk_in; no internal synchronizer.
- period_o  output  WIDTH  last captured interval, in clk_in cycles.
- valid_o  output  1  one-cycle strobe: period_o just updated.
- overflow_o  output  1  sticky: interval exceeded 2^WIDTH-1 cycles.
- busy_o  output  1  1 while in state MEASURE.
- state_o  output  2  current state: 00 IDLE, 01 ARM, 10 MEASURE.

Behaviour:
- Interface: one clock, clk_in. Reset reset_in is synchronous and active-high.
- Reset (reset_in=1 at a clock edge) sets:
  - period_o = 0, valid_o = 0, overflow_o = 0, busy_o = 0.
  - State = IDLE, counter = 0, pulse_d = 0.
- Reset has priority over every other input, including mid-measurement. The next cycle after reset always starts from IDLE.
- Edge detect:
  - pulse_d <= pulse_in every cycle in every state, including IDLE.
  - rise = pulse_in & ~pulse_d.
  - Enabling while pulse_in is held high therefore creates no false edge.
- IDLE:
  - counter = 0.
  - Moves to ARM on the cycle enable_in = 1.
- ARM:
  - Waits for a rise.
  - On rise: counter <= 1, go to MEASURE. This first edge produces no valid_o.
- MEASURE:
  - Without a rise, counter <= counter + 1 each cycle.
  - On rise:
    - period_o <= counter.
    - valid_o = 1 in the following cycle only.
    - counter <= 1; stay in MEASURE.
  - Result: edges at cycles t and t+N give period_o = N.
  - Minimum reportable period is 2, because pulse_in must drop between edges.
- Overflow:
  - Condition: in MEASURE, counter = 2^WIDTH-1 and no rise in this cycle.
  - Actions: overflow_o <= 1, counter <= 0, go to ARM.
  - period_o and valid_o are not updated.
  - The next rise restarts measurement; it does not produce a sample.
  - A rise in the same cycle the counter reaches 2^WIDTH-1 is a valid capture of 2^WIDTH-1. No overflow occurs.
- enable_in = 0 in ARM or MEASURE:
  - Next state IDLE, counter <= 0, in-flight interval discarded.
  - period_o and overflow_o are retained; valid_o is not raised.
  - A rise in that same cycle is ignored.
- clear_in = 1:
  - overflow_o <= 0 and period_o <= 0 next cycle. State and counter are unaffected.
  - If a capture occurs in the same cycle, the capture wins: period_o takes the new value and valid_o strobes. overflow_o is still cleared.
  - If an overflow occurs in the same cycle, the set wins: overflow_o = 1.
- Output timing:
  - All outputs are registered; no combinational path from any input to any output.
  - Capture latency: valid_o and the new period_o appear 1 cycle after the cycle in which rise is detected.
- busy_o = 1 exactly when state = MEASURE.

Test Plan:
- Reset:
  - Stimulus: reset_in=1 for 2 cycles with pulse_in toggling, then release.
  - Required: all outputs 0, state_o=00. First cycle after release still IDLE, or ARM if enable_in=1.
- Nominal period:
  - Stimulus: enable_in=1, clock period 40 ns; pulse_in one cycle high every 16 cycles, 4 pulses.
  - Required: first pulse gives no valid_o. Then 3 valid_o strobes, each with period_o=16. busy_o=1 from the cycle after the first pulse.
- Held level:
  - Stimulus: pulse_in high for 5 cycles, low for 3, repeated.
  - Required: period_o=8 on each strobe; no strobe during the high phase.
- Overflow:
  - Stimulus: WIDTH=4, edge, then 20 quiet cycles, then edges 6 cycles apart.
  - Required: overflow_o rises 15 cycles after the first edge and state_o=01. Next edge gives no strobe. Following edge gives period_o=6 with overflow_o still 1. clear_in=1 then overflow_o=0 and period_o=0.
- Overflow boundary:
  - Stimulus: WIDTH=4, edges exactly 15 cycles apart.
  - Required: period_o=15, overflow_o stays 0.
- Disable and simultaneous events:
  - Stimulus: drop enable_in mid-interval in the same cycle as a rise; re-enable with pulse_in already high.
  - Required: no strobe, state_o=00, period_o unchanged. After re-enable, no capture until the next genuine low-to-high transition.
  - Stimulus: clear_in together with a capture.
  - Required: period_o takes the new value and valid_o=1.
